// File: rtl/shift_loader_pkg.sv
// ----------------------------------------------------------------------------
// shift_loader_pkg
// Purpose : Shared types and default sizing for the shift_loader block.
//   state_t      - transaction FSM states (IDLE -> LOAD -> CAPTURE -> DRAIN)
//   DEF_N_CH     - default number of serial operand channels
//   DEF_WIDTH    - default bits per channel operand
//   DEF_OUT_W    - default width of the result returned by the compressor
// ----------------------------------------------------------------------------
package shift_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DRAIN   = 2'd3
    } state_t;

    localparam int DEF_N_CH  = 27;
    localparam int DEF_WIDTH = 27;
    localparam int DEF_OUT_W = 32;

endpackage : shift_loader_pkg

// File: rtl/shift_loader_lane.sv
// ----------------------------------------------------------------------------
// shift_lane
// Purpose : One serial-in / parallel-out operand channel.
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset, clears q
//   clr   - synchronous clear (start of a new load), wins over en
//   en    - shift q left by one, din enters bit 0
//   din   - serial input bit
//   q     - parallel operand, first-shifted bit ends in the MSB
// ----------------------------------------------------------------------------
module shift_lane #(
    parameter int WIDTH = 27
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            // Shift-and-or form stays legal when WIDTH is 1.
            q <= (q << 1) | WIDTH'(din);
        end
    end

endmodule : shift_lane

// File: rtl/shift_loader.sv
// ----------------------------------------------------------------------------
// shift_loader
// Purpose : Loads N_CH serial operands in parallel, presents them to an
//           external combinational compressor, captures the compressor result
//           and streams it back out LSB first.
//   clk, rst_n     - clock (rising edge) and asynchronous active-low reset
//   start          - begin a transaction (only honoured in IDLE)
//   shift_en       - qualifies one serial bit per channel (only in LOAD)
//   src_i          - one serial bit per channel
//   src_o          - parallel operands, channel k at [k*WIDTH +: WIDTH]
//   op_valid       - src_o complete and stable (CAPTURE and DRAIN)
//   res_i          - compressor result, combinational from src_o
//   res_ser        - serialised result bit, LSB first
//   res_ser_valid  - res_ser qualifier
//   busy           - high in every state except IDLE
//   done           - one-cycle pulse on the final DRAIN cycle
// ----------------------------------------------------------------------------
module shift_loader
    import shift_loader_pkg::*;
#(
    parameter int N_CH  = DEF_N_CH,
    parameter int WIDTH = DEF_WIDTH,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  shift_en,
    input  logic [N_CH-1:0]       src_i,
    output logic [N_CH*WIDTH-1:0] src_o,
    output logic                  op_valid,
    input  logic [OUT_W-1:0]      res_i,
    output logic                  res_ser,
    output logic                  res_ser_valid,
    output logic                  busy,
    output logic                  done
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int DRN_W = $clog2(OUT_W + 1);

    // Terminal values are compared before the increment, so the shift that
    // makes the count reach WIDTH (or OUT_W) is the one that leaves the state.
    localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(WIDTH - 1);
    localparam logic [DRN_W-1:0] LAST_DRAIN = DRN_W'(OUT_W - 1);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   bit_cnt;
    logic [DRN_W-1:0]   drain_cnt;
    logic [OUT_W-1:0]   res_sr;
    logic               lane_clr;
    logic               lane_en;

    // ------------------------------------------------------------------
    // Operand lanes
    // ------------------------------------------------------------------
    for (genvar k = 0; k < N_CH; k++) begin : g_lane
        shift_lane #(
            .WIDTH (WIDTH)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (lane_clr),
            .en    (lane_en),
            .din   (src_i[k]),
            .q     (src_o[k*WIDTH +: WIDTH])
        );
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Counters and result shift register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            drain_cnt <= '0;
            res_sr    <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) bit_cnt <= '0;
                end
                ST_LOAD: begin
                    if (shift_en) bit_cnt <= bit_cnt + CNT_W'(1);
                end
                ST_CAPTURE: begin
                    res_sr    <= res_i;
                    drain_cnt <= '0;
                end
                ST_DRAIN: begin
                    res_sr    <= res_sr >> 1;
                    drain_cnt <= drain_cnt + DRN_W'(1);
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Next-state and outputs
    // ------------------------------------------------------------------
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_nxt     = state;
        lane_clr      = 1'b0;
        lane_en       = 1'b0;
        op_valid      = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        res_ser       = 1'b0;
        res_ser_valid = 1'b0;

        unique case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    lane_clr  = 1'b1;
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (shift_en) begin
                    lane_en = 1'b1;
                    if (bit_cnt == LAST_BIT) state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                op_valid  = 1'b1;
                state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                op_valid      = 1'b1;
                res_ser       = res_sr[0];
                res_ser_valid = 1'b1;
                if (drain_cnt == LAST_DRAIN) begin
                    done      = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule : shift_loader

// File: tb/tb_shift_loader.sv
// ----------------------------------------------------------------------------
// tb_shift_loader
// Directed bench for shift_loader: a default-sized instance fed by a small
// compressor model (constant override or population count of src_o), and a
// minimal instance (N_CH=4, WIDTH=1, OUT_W=1) fed by the parity of src_o.
// ----------------------------------------------------------------------------
module tb_shift_loader;

    localparam int N_CH  = 27;
    localparam int WIDTH = 27;
    localparam int OUT_W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Default instance
    logic                  start = 1'b0;
    logic                  shift_en = 1'b0;
    logic [N_CH-1:0]       src_i = '0;
    logic [N_CH*WIDTH-1:0] src_o;
    logic                  op_valid;
    logic [OUT_W-1:0]      res_i;
    logic                  res_ser;
    logic                  res_ser_valid;
    logic                  busy;
    logic                  done;

    // Compressor model
    logic                  use_const = 1'b1;
    logic [OUT_W-1:0]      const_res = '0;
    always_comb res_i = use_const ? const_res : OUT_W'($countones(src_o));

    shift_loader #(.N_CH(N_CH), .WIDTH(WIDTH), .OUT_W(OUT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .shift_en      (shift_en),
        .src_i         (src_i),
        .src_o         (src_o),
        .op_valid      (op_valid),
        .res_i         (res_i),
        .res_ser       (res_ser),
        .res_ser_valid (res_ser_valid),
        .busy          (busy),
        .done          (done)
    );

    // Minimal instance
    logic       start2 = 1'b0;
    logic       shift_en2 = 1'b0;
    logic [3:0] src_i2 = '0;
    logic [3:0] src_o2;
    logic       op_valid2;
    logic       res_i2;
    logic       res_ser2;
    logic       res_ser_valid2;
    logic       busy2;
    logic       done2;

    always_comb res_i2 = ^src_o2;

    shift_loader #(.N_CH(4), .WIDTH(1), .OUT_W(1)) dut2 (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start2),
        .shift_en      (shift_en2),
        .src_i         (src_i2),
        .src_o         (src_o2),
        .op_valid      (op_valid2),
        .res_i         (res_i2),
        .res_ser       (res_ser2),
        .res_ser_valid (res_ser_valid2),
        .busy          (busy2),
        .done          (done2)
    );

    int errors = 0;
    int checks = 0;

    // Expected operands after a full load (see load_operands stimulus)
    localparam logic [WIDTH-1:0] EXP_CH0 = 27'h4000000;
    localparam logic [WIDTH-1:0] EXP_CH1 = 27'h7FFFFFF;
    localparam logic [WIDTH-1:0] EXP_CH2 = 27'h5555555;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] get_ch(input int k);
        return src_o[k*WIDTH +: WIDTH];
    endfunction

    // Pulses start, then performs WIDTH qualified shifts. Channel 0 gets 1
    // then zeros, channel 1 all ones, channel 2 alternates starting with 1.
    // With gated=1 every qualified shift is preceded by a shift_en=0 cycle
    // carrying all-ones data that must be ignored. With poke=1 start is held
    // high on qualified shift 5. Ends in CAPTURE.
    task automatic load_operands(input string tag, input bit gated, input bit poke);
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || op_valid !== 1'b0 || src_o !== '0) begin
            errors++;
            $display("FAIL %s_load_entry: busy=%b op_valid=%b src_o_zero=%b, want 1 0 1",
                     tag, busy, op_valid, (src_o == '0));
        end
        for (int q = 0; q < WIDTH; q++) begin
            if (gated) begin
                shift_en = 1'b0;
                src_i    = '1;
                tick();
                checks++;
                if (op_valid !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_gap%0d: op_valid=%b busy=%b, want 0 1",
                             tag, q, op_valid, busy);
                end
            end
            shift_en = 1'b1;
            start    = poke && (q == 5);
            src_i    = '0;
            src_i[0] = (q == 0);
            src_i[1] = 1'b1;
            src_i[2] = (q % 2 == 0);
            tick();
            shift_en = 1'b0;
            start    = 1'b0;
            src_i    = '0;
            checks++;
            if (op_valid !== (q == WIDTH - 1)) begin
                errors++;
                $display("FAIL %s_op_valid_shift%0d: got %b want %b",
                         tag, q, op_valid, (q == WIDTH - 1));
            end
        end
        checks++;
        if (get_ch(0) !== EXP_CH0 || get_ch(1) !== EXP_CH1 || get_ch(2) !== EXP_CH2 ||
            get_ch(3) !== '0 || get_ch(N_CH-1) !== '0) begin
            errors++;
            $display("FAIL %s_src_o: ch0=%h ch1=%h ch2=%h ch3=%h ch26=%h want %h %h %h 0 0",
                     tag, get_ch(0), get_ch(1), get_ch(2), get_ch(3), get_ch(N_CH-1),
                     EXP_CH0, EXP_CH1, EXP_CH2);
        end
    endtask

    // Starts in CAPTURE; checks OUT_W drained bits against exp, LSB first.
    task automatic drain_check(input string tag, input logic [OUT_W-1:0] exp, input bit poke);
        checks++;
        if (res_ser_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_capture: res_ser_valid=%b done=%b busy=%b, want 0 0 1",
                     tag, res_ser_valid, done, busy);
        end
        tick();
        for (int j = 0; j < OUT_W; j++) begin
            checks++;
            if (res_ser_valid !== 1'b1 || res_ser !== exp[j] || done !== (j == OUT_W - 1) ||
                op_valid !== 1'b1) begin
                errors++;
                $display("FAIL %s_drain_bit%0d: valid=%b bit=%b done=%b op_valid=%b, want 1 %b %b 1",
                         tag, j, res_ser_valid, res_ser, done, op_valid, exp[j], (j == OUT_W - 1));
            end
            start = poke && (j == 10);
            tick();
            start = 1'b0;
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || op_valid !== 1'b0 || res_ser_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_post_drain: busy=%b done=%b op_valid=%b valid=%b, want 0 0 0 0",
                     tag, busy, done, op_valid, res_ser_valid);
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if (src_o !== '0 || op_valid !== 1'b0 || res_ser !== 1'b0 || res_ser_valid !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: src_o_zero=%b op_valid=%b res_ser=%b valid=%b busy=%b done=%b, want 1 0 0 0 0 0",
                     (src_o == '0), op_valid, res_ser, res_ser_valid, busy, done);
        end
        checks++;
        if (src_o2 !== '0 || op_valid2 !== 1'b0 || busy2 !== 1'b0 || done2 !== 1'b0 ||
            res_ser_valid2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs_small: src_o=%b op_valid=%b busy=%b done=%b valid=%b, want 0 0 0 0 0",
                     src_o2, op_valid2, busy2, done2, res_ser_valid2);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_load_drain();
        use_const = 1'b1;
        const_res = 32'hA5A5_0001;
        load_operands("basic", 1'b0, 1'b0);
        drain_check("basic", 32'hA5A5_0001, 1'b0);
        tick();
        tick();
        checks++;
        if (get_ch(0) !== EXP_CH0 || get_ch(1) !== EXP_CH1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: ch0=%h ch1=%h busy=%b, want %h %h 0",
                     get_ch(0), get_ch(1), busy, EXP_CH0, EXP_CH1);
        end
    endtask

    task automatic test_gated_shift();
        const_res = 32'h0000_00F0;
        load_operands("gated", 1'b1, 1'b0);
        drain_check("gated", 32'h0000_00F0, 1'b0);
    endtask

    task automatic test_start_ignored();
        const_res = 32'h8000_0003;
        load_operands("poke", 1'b0, 1'b1);
        drain_check("poke", 32'h8000_0003, 1'b1);
    endtask

    task automatic test_reset_mid();
        const_res = 32'hFFFF_FFFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int q = 0; q < 10; q++) begin
            shift_en = 1'b1;
            src_i    = '1;
            tick();
        end
        shift_en = 1'b0;
        src_i    = '0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (src_o !== '0 || busy !== 1'b0 || op_valid !== 1'b0 || done !== 1'b0 ||
            res_ser_valid !== 1'b0 || res_ser !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: src_o_zero=%b busy=%b op_valid=%b done=%b valid=%b res_ser=%b, want 1 0 0 0 0 0",
                     (src_o == '0), busy, op_valid, done, res_ser_valid, res_ser);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold%0d: done=%b busy=%b, want 0 0", c, done, busy);
            end
        end
        rst_n = 1'b1;
        tick();
        // Post-reset transaction through the population-count compressor:
        // 1 (ch0) + 27 (ch1) + 14 (ch2) = 42 ones.
        use_const = 1'b0;
        load_operands("after_rst", 1'b0, 1'b0);
        checks++;
        if (res_i !== 32'd42) begin
            errors++;
            $display("FAIL after_rst_res_i: got %0d want 42", res_i);
        end
        drain_check("after_rst", 32'd42, 1'b0);
    endtask

    task automatic test_small();
        logic [3:0] vec [2];
        logic       par [2];
        vec[0] = 4'b1011; par[0] = 1'b1;
        vec[1] = 4'b0110; par[1] = 1'b0;
        for (int v = 0; v < 2; v++) begin
            start2 = 1'b1;
            tick();
            start2 = 1'b0;
            checks++;
            if (busy2 !== 1'b1 || op_valid2 !== 1'b0 || src_o2 !== 4'b0000) begin
                errors++;
                $display("FAIL small%0d_load: busy=%b op_valid=%b src_o=%b, want 1 0 0000",
                         v, busy2, op_valid2, src_o2);
            end
            shift_en2 = 1'b1;
            src_i2    = vec[v];
            tick();
            shift_en2 = 1'b0;
            src_i2    = '0;
            checks++;
            if (op_valid2 !== 1'b1 || src_o2 !== vec[v] || res_ser_valid2 !== 1'b0) begin
                errors++;
                $display("FAIL small%0d_capture: op_valid=%b src_o=%b valid=%b, want 1 %b 0",
                         v, op_valid2, src_o2, res_ser_valid2, vec[v]);
            end
            tick();
            checks++;
            if (res_ser_valid2 !== 1'b1 || res_ser2 !== par[v] || done2 !== 1'b1) begin
                errors++;
                $display("FAIL small%0d_drain: valid=%b bit=%b done=%b, want 1 %b 1",
                         v, res_ser_valid2, res_ser2, done2, par[v]);
            end
            tick();
            checks++;
            if (busy2 !== 1'b0 || done2 !== 1'b0 || src_o2 !== vec[v]) begin
                errors++;
                $display("FAIL small%0d_idle: busy=%b done=%b src_o=%b, want 0 0 %b",
                         v, busy2, done2, src_o2, vec[v]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_drain();
        test_gated_shift();
        test_start_ignored();
        test_reset_mid();
        test_small();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_shift_loader

// File: doc/shift_loader.md
SHIFT_LOADER -- requirements
Module: shift_loader

Interface
REQ-001 SHALL have parameter N_CH, default 27, number of serial operand channels.
REQ-002 SHALL have parameter WIDTH, default 27, bits per channel operand.
REQ-003 SHALL have parameter OUT_W, default 32, result width returned by the downstream compressor.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  begin a load/compute/drain transaction.
REQ-007 SHALL have port shift_en  input  1  qualifies one serial bit per channel.
REQ-008 SHALL have port src_i  input  N_CH  serial bit per channel.
REQ-009 SHALL have port src_o  output  N_CH*WIDTH  parallel operands; channel k at bits [k*WIDTH +: WIDTH].
REQ-010 SHALL have port op_valid  output  1  src_o complete and stable.
REQ-011 SHALL have port res_i  input  OUT_W  compressor result, combinational from src_o.
REQ-012 SHALL have port res_ser  output  1  serialised result bit.
REQ-013 SHALL have port res_ser_valid  output  1  res_ser qualifier.
REQ-014 SHALL have port busy  output  1  high in any state except IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse at transaction end.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, CAPTURE, DRAIN.
REQ-017 IDLE: start=1 SHALL go to LOAD, clear the bit counter; src_o SHALL be zeroed on LOAD entry.
REQ-018 LOAD: each cycle with shift_en=1 SHALL shift every channel left one place, src_i[k] into bit 0 of channel k, and increment bit counter; shift_en=0 SHALL hold all state.
REQ-019 LOAD: the shift that makes the counter reach WIDTH SHALL move to CAPTURE next cycle; counter width SHALL be $clog2(WIDTH+1).
REQ-020 op_valid SHALL be 1 in CAPTURE and DRAIN, 0 otherwise.
REQ-021 CAPTURE (exactly one cycle): SHALL register res_i into an OUT_W result shift register, clear drain counter, go to DRAIN.
REQ-022 DRAIN: each cycle SHALL present result LSB first on res_ser with res_ser_valid=1, shift right; after OUT_W bits SHALL return to IDLE with done=1 on that final DRAIN cycle.
REQ-023 start SHALL be ignored in all states except IDLE; shift_en SHALL be ignored outside LOAD.
REQ-024 src_o SHALL hold its last loaded value in IDLE after a transaction, until the next start.
REQ-025 WIDTH=1 SHALL reach CAPTURE after one shift; OUT_W=1 SHALL drain in one cycle.

Reset
REQ-026 rst_n=0 SHALL, asynchronously, force state IDLE, src_o=0, all counters 0, result register 0, op_valid=0, res_ser=0, res_ser_valid=0, busy=0, done=0.
REQ-027 Reset asserted mid-LOAD or mid-DRAIN SHALL abandon the transaction with no done pulse.

Structure
REQ-028 FSM state enum and default N_CH/WIDTH/OUT_W constants SHALL live in shared package shift_loader_pkg.
REQ-029 Per-channel shifter SHALL be one sub-module, shift_lane (WIDTH-bit, enable, clear), instantiated N_CH times by generate.
REQ-030 Compressor SHALL NOT be instantiated inside; bench connects src_o->compressor->res_i.

Verification
REQ-031 Defaults, start, 27 shifts with channel 0 fed 1 then zeros -> src_o ch0=27'h4000000, CAPTURE at cycle 28, op_valid=1.
REQ-032 res_i=32'hA5A5_0001 at CAPTURE -> res_ser sequence 1,0,0,...(LSB first) for 32 cycles, done pulse on 32nd, busy=0 after.
REQ-033 shift_en toggled every other cycle in LOAD -> exactly WIDTH qualified shifts, no early CAPTURE.
REQ-034 start pulsed during LOAD and DRAIN -> no state change, counters unaffected.
REQ-035 rst_n low at shift 10 -> all outputs 0 immediately, no done; subsequent full transaction correct.
REQ-036 N_CH=4, WIDTH=1, OUT_W=1 -> LOAD 1 cycle, CAPTURE 1, DRAIN 1, done after 3 cycles post-LOAD entry.
